// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register-dump FSM state encoding.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

endpackage : cpu_pkg

// File: rtl/reg_dump_unit.sv
// Walks a wrapping register range through one read port and streams each word over valid/ready.
// Optional trailing checksum word is enabled with `define DUMP_CHECKSUM_EN.
module reg_dump_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_data_d = rd_data;
        out_addr_d = addr_q;
`ifdef DUMP_CHECKSUM_EN
        out_last_d = 1'b0;
`else
        out_last_d = (addr_q == last_q);
`endif
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (addr_q == last_q) begin
`ifdef DUMP_CHECKSUM_EN
            // Fold the final register into the checksum word sent next.
            sum_d      = sum_q + out_data_q;
            out_data_d = sum_q + out_data_q;
            out_addr_d = '0;
            out_last_d = 1'b1;
            state_d    = CSUM;
`else
            state_d    = DONE;
`endif
          end else begin
`ifdef DUMP_CHECKSUM_EN
            sum_d   = sum_q + out_data_q;
`endif
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        if (out_ready) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Read address is the registered walk pointer, so rd_data is settled by the FETCH edge.
  assign rd_addr   = addr_q;
  assign out_valid = (state_q == SEND) || (state_q == CSUM);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule : reg_dump_unit

// File: tb/tb_reg_dump_unit.sv
// Directed, table-driven bench for reg_dump_unit with a behavioural register file (rf[i] = A000+i).
module tb_reg_dump_unit;
  import cpu_pkg::*;

`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid, out_ready, out_last, busy, done;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf [NUM_REGS];
  assign rd_data = rf[rd_addr];

  reg_dump_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  l;
    int          stall;
    bit          poke;
    int          n;
    logic [15:0] csum;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q_data[$];
  logic [3:0]  q_addr[$];
  logic        q_last[$];
  int          last_xfer_cyc, done_cyc;
  bit          saw_done, busy_err, stall_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_dump(input logic [3:0] f, input logic [3:0] l, input int stall_n,
                         input bit poke, input int abort_after);
    int          stall_left;
    int          cyc;
    bit          holding;
    logic [15:0] held;
    q_data.delete(); q_addr.delete(); q_last.delete();
    saw_done = 0; busy_err = 0; stall_err = 0;
    last_xfer_cyc = -1; done_cyc = -1;
    stall_left = stall_n; cyc = 0; holding = 0; held = '0;
    @(negedge clk);
    first_addr = f; last_addr = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; first_addr = 4'd0; last_addr = 4'd15;
    for (int i = 0; i < 400; i++) begin
      cyc++;
      start     = 1'b0;
      out_ready = 1'b1;
      if (poke && cyc == 2) start = 1'b1;
      if (out_valid && q_data.size() == 0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (!holding) begin
          held = out_data; holding = 1;
        end else if (out_data !== held || !out_valid) begin
          stall_err = 1;
        end
      end
      if (!busy) busy_err = 1;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_addr.push_back(out_addr);
        q_last.push_back(out_last);
        last_xfer_cyc = cyc;
        if (abort_after > 0 && q_data.size() == abort_after) break;
      end
      if (done) begin
        saw_done = 1;
        done_cyc = cyc;
        if (poke) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input vec_t v);
    int idle_bad;
    logic [15:0] exp_d;
    do_dump(v.f, v.l, v.stall, v.poke, 0);
    check({tag, " words"}, q_data.size(), v.n + CS);
    for (int k = 0; k < v.n && k < q_data.size(); k++) begin
      exp_d = 16'hA000 + 16'((v.f + k) & 15);
      check($sformatf("%s data[%0d]", tag, k), q_data[k], exp_d);
      check($sformatf("%s addr[%0d]", tag, k), q_addr[k], (v.f + k) & 15);
      check($sformatf("%s last[%0d]", tag, k), q_last[k], (k == v.n - 1) && (CS == 0));
    end
`ifdef DUMP_CHECKSUM_EN
    if (q_data.size() > v.n) begin
      check({tag, " csum data"}, q_data[v.n], v.csum);
      check({tag, " csum addr"}, q_addr[v.n], 0);
      check({tag, " csum last"}, q_last[v.n], 1);
    end
`endif
    check({tag, " done seen"}, saw_done, 1);
    check({tag, " last xfer cycle"}, last_xfer_cyc, 2 * v.n + v.stall + CS);
    check({tag, " done cycle"}, done_cyc, last_xfer_cyc + 1);
    check({tag, " busy held"}, busy_err, 0);
    check({tag, " stall stable"}, stall_err, 0);
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy || done) idle_bad++;
    end
    check({tag, " idle after"}, idle_bad, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int nodone;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 16'hA000 + 16'(i);
    vecs[0] = '{4'd0,  4'd15, 0, 1'b0, 16, 16'h0078};
    vecs[1] = '{4'd14, 4'd1,  0, 1'b0, 4,  16'h801E};
    vecs[2] = '{4'd3,  4'd4,  5, 1'b0, 2,  16'h4007};
    vecs[3] = '{4'd7,  4'd7,  0, 1'b1, 1,  16'hA007};
    vecs[4] = '{4'd0,  4'd3,  0, 1'b0, 4,  16'h8006};

    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    first_addr = 4'd5; last_addr = 4'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset outs", {out_data, out_addr, out_last, rd_addr}, 0);
    reset = 1'b1;

    for (int t = 0; t < 5; t++) verify($sformatf("vec%0d", t), vecs[t]);

    // Abort a full dump right after its third accepted word.
    do_dump(4'd0, 4'd15, 0, 1'b0, 3);
    check("abort words", q_data.size(), 3);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort valid", out_valid, 0);
    check("abort busy", busy, 0);
    check("abort outs", {out_data, out_addr, out_last, rd_addr, done}, 0);
    reset = 1'b1;
    nodone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || out_valid) nodone++;
    end
    check("abort quiet", nodone, 0);
    verify("after abort", '{4'd0, 4'd1, 0, 1'b0, 2, 16'h4001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_dump_unit
